// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared definitions for the bit-serial adder controller.
//   - DEFAULT_WIDTH / MIN_WIDTH / MAX_WIDTH : operand width default and range
//   - state_t                               : controller states IDLE/RUN/DONE
//   - cnt_width()                           : bit counter width for a WIDTH
// ---------------------------------------------------------------------------
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int MIN_WIDTH     = 2;
   localparam int MAX_WIDTH     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..width-1.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Start/Done request interface of the bit-serial adder.
//   master : requesting logic (drives operands and Start, observes results)
//   slave  : serial_adder_ctrl
//   Signals:
//     Data_in_A/B [WIDTH], Data_in_Cin, Start       requester -> adder
//     Busy, Done, Data_out_Sum [WIDTH], Data_out_Carry adder -> requester
//     Data_out_Overflow                             only with SERIAL_ADD_OVERFLOW_EN
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] Data_in_A;
   logic [WIDTH-1:0] Data_in_B;
   logic             Data_in_Cin;
   logic             Start;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Data_out_Sum;
   logic             Data_out_Carry;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic             Data_out_Overflow;
`endif

   modport master (
      output Data_in_A, Data_in_B, Data_in_Cin, Start,
`ifdef SERIAL_ADD_OVERFLOW_EN
      input  Data_out_Overflow,
`endif
      input  Busy, Done, Data_out_Sum, Data_out_Carry
   );

   modport slave (
      input  Data_in_A, Data_in_B, Data_in_Cin, Start,
`ifdef SERIAL_ADD_OVERFLOW_EN
      output Data_out_Overflow,
`endif
      output Busy, Done, Data_out_Sum, Data_out_Carry
   );

endinterface

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit full-adder cell.
//   Data_in_A, Data_in_B, Data_in_C : addend bits and carry-in
//   Data_out_Sum, Data_out_Carry    : sum bit and carry-out
// ---------------------------------------------------------------------------
module full_adder (
   input  logic Data_in_A,
   input  logic Data_in_B,
   input  logic Data_in_C,
   output logic Data_out_Sum,
   output logic Data_out_Carry
);

   assign Data_out_Sum   = Data_in_A ^ Data_in_B ^ Data_in_C;
   assign Data_out_Carry = (Data_in_A & Data_in_B) | (Data_in_C & (Data_in_A ^ Data_in_B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. Operands are shifted LSB-first through one
//   full_adder cell; the ripple carry lives in a flip-flop between cycles and
//   sum bits are collected in a shift register.
//   A Start accepted in IDLE is followed by WIDTH RUN cycles and one DONE
//   cycle (Done high), giving one add per WIDTH+2 cycles.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  serial_adder_ctrl_if.slave (operands, Start, Busy, Done, results)
//   Build option:
//     SERIAL_ADD_OVERFLOW_EN adds Data_out_Overflow (signed overflow of the add)
// ---------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   serial_adder_ctrl_if.slave bus
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH out of range 2..32");
   end

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             cy;
   logic [CNT_W-1:0] cnt;
   // Holds the WIDTH-1 sum bits already produced; the last bit comes straight
   // from the cell on the final RUN edge, so a full WIDTH-bit register is not
   // needed.
   logic [WIDTH-2:0] sum_sh;
   logic [WIDTH-1:0] sum_next;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic             ovf_q;
`endif

   logic             fa_sum;
   logic             fa_carry;

   full_adder u_cell (
      .Data_in_A      (sh_a[0]),
      .Data_in_B      (sh_b[0]),
      .Data_in_C      (cy),
      .Data_out_Sum   (fa_sum),
      .Data_out_Carry (fa_carry)
   );

   // New bit enters at the top; after the last RUN edge this is the full sum.
   assign sum_next = {fa_sum, sum_sh};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, exactly like the flops it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every register, including the datapath shift registers, is
         // reset so a discarded operation leaves nothing behind.
         state   <= IDLE;
         sh_a    <= '0;
         sh_b    <= '0;
         cy      <= 1'b0;
         cnt     <= '0;
         sum_sh  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         // NOTE: Done defaults low here so it can only be a one-cycle pulse.
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.Start) begin
                  sh_a   <= bus.Data_in_A;
                  sh_b   <= bus.Data_in_B;
                  cy     <= bus.Data_in_Cin;
                  cnt    <= '0;
                  sum_sh <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end

            RUN: begin
               cy     <= fa_carry;
               sum_sh <= sum_next[WIDTH-1:1];
               sh_a   <= sh_a >> 1;
               sh_b   <= sh_b >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  sum_q   <= sum_next;
                  carry_q <= fa_carry;
`ifdef SERIAL_ADD_OVERFLOW_EN
                  // Carry into the MSB is cy; carry out of it is the cell carry.
                  ovf_q   <= cy ^ fa_carry;
`endif
                  done_q  <= 1'b1;
                  state   <= DONE;
               end
            end

            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.Busy           = busy_q;
   assign bus.Done           = done_q;
   assign bus.Data_out_Sum   = sum_q;
   assign bus.Data_out_Carry = carry_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
   assign bus.Data_out_Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH = 8). Expected results
//   come from plain integer addition of the operands.
//   Honours SERIAL_ADD_OVERFLOW_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [W-1:0] last_sum   = '0;
   logic         last_carry = 1'b0;
   logic         last_ovf   = 1'b0;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: the arithmetic sum and signed-overflow rule.
   function automatic logic [W:0] ref_total(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
      int unsigned t;
      t = int'(a) + int'(b) + int'(cin);
      return t[W:0];
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W:0] total);
      return (a[W-1] == b[W-1]) && (total[W-1] != a[W-1]);
   endfunction

   task automatic check_outputs(input string tag, input logic [W-1:0] s, input logic c,
                                input logic o);
      check({tag, " sum"}, 64'(bus.Data_out_Sum), 64'(s));
      check({tag, " carry"}, 64'(bus.Data_out_Carry), 64'(c));
`ifdef SERIAL_ADD_OVERFLOW_EN
      check({tag, " overflow"}, 64'(bus.Data_out_Overflow), 64'(o));
`else
      if (o !== o) check({tag, " overflow"}, 64'(o), 64'(0));
`endif
   endtask

   // One full operation: Start accepted at edge k, Done expected after edge k+W.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
      logic [W:0] total;
      int lat;
      total = ref_total(a, b, cin);
      @(negedge clk);
      bus.Data_in_A   = a;
      bus.Data_in_B   = b;
      bus.Data_in_Cin = cin;
      bus.Start       = 1'b1;
      @(negedge clk);
      bus.Start       = 1'b0;
      bus.Data_in_A   = W'($urandom);
      bus.Data_in_B   = W'($urandom);
      bus.Data_in_Cin = 1'($urandom);
      check({tag, " busy"}, 64'(bus.Busy), 64'(1));
      check({tag, " held sum"}, 64'(bus.Data_out_Sum), 64'(last_sum));
      check({tag, " held carry"}, 64'(bus.Data_out_Carry), 64'(last_carry));
      lat = 0;
      while (bus.Done !== 1'b1 && lat < 4 * W) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(W));
      check_outputs(tag, total[W-1:0], total[W], ref_ovf(a, b, total));
      last_sum   = total[W-1:0];
      last_carry = total[W];
      last_ovf   = ref_ovf(a, b, total);
      @(negedge clk);
      check({tag, " done pulse"}, 64'(bus.Done), 64'(0));
      check({tag, " idle"}, 64'(bus.Busy), 64'(0));
   endtask

   initial begin
      int dones;
      int t[3];
      int unstable;
      logic [W:0] total;
      logic [W-1:0] got_sum;
      logic         got_carry;

      rst             = 1'b1;
      bus.Start       = 1'b0;
      bus.Data_in_A   = '0;
      bus.Data_in_B   = '0;
      bus.Data_in_Cin = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(bus.Busy), 64'(0));
      check("reset done", 64'(bus.Done), 64'(0));
      check_outputs("reset", '0, 1'b0, 1'b0);
      rst = 1'b0;

      // Directed arithmetic cases.
      run_op("5A+33", 8'h5A, 8'h33, 1'b0);
      run_op("FF+01", 8'hFF, 8'h01, 1'b0);
      run_op("FF+FF+1", 8'hFF, 8'hFF, 1'b1);
      run_op("7F+01", 8'h7F, 8'h01, 1'b0);
      run_op("80+80", 8'h80, 8'h80, 1'b0);

      // Start with new operands during RUN (sampled at edge k+3) is ignored.
      @(negedge clk);
      bus.Data_in_A   = 8'h5A;
      bus.Data_in_B   = 8'h33;
      bus.Data_in_Cin = 1'b0;
      bus.Start       = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (2) @(negedge clk);
      bus.Data_in_A   = 8'hFF;
      bus.Data_in_B   = 8'hFF;
      bus.Data_in_Cin = 1'b1;
      bus.Start       = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      dones     = 0;
      got_sum   = '0;
      got_carry = 1'b0;
      for (int i = 0; i < 3 * W; i++) begin
         if (bus.Done === 1'b1) begin
            dones++;
            got_sum   = bus.Data_out_Sum;
            got_carry = bus.Data_out_Carry;
         end
         @(negedge clk);
      end
      check("ignored start done count", 64'(dones), 64'(1));
      check("ignored start sum", 64'(got_sum), 64'(8'h8D));
      check("ignored start carry", 64'(got_carry), 64'(0));
      last_sum   = 8'h8D;
      last_carry = 1'b0;

      // Reset asserted at edge k+4 of a run discards it.
      @(negedge clk);
      bus.Data_in_A   = 8'hC3;
      bus.Data_in_B   = 8'h5E;
      bus.Data_in_Cin = 1'b1;
      bus.Start       = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun reset busy", 64'(bus.Busy), 64'(0));
      check("midrun reset done", 64'(bus.Done), 64'(0));
      check_outputs("midrun reset", '0, 1'b0, 1'b0);
      dones = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (bus.Done === 1'b1 || bus.Busy === 1'b1) dones++;
      end
      check("no activity after reset", 64'(dones), 64'(0));
      last_sum   = '0;
      last_carry = 1'b0;
      last_ovf   = 1'b0;
      run_op("fresh after reset", 8'hC3, 8'h5E, 1'b1);

      // Start held high for 30 edges: a new add every W+2 cycles.
      total = ref_total(8'h3C, 8'h0F, 1'b1);
      @(negedge clk);
      bus.Data_in_A   = 8'h3C;
      bus.Data_in_B   = 8'h0F;
      bus.Data_in_Cin = 1'b1;
      bus.Start       = 1'b1;
      dones    = 0;
      unstable = 0;
      t        = '{0, 0, 0};
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.Done === 1'b1) begin
            if (dones < 3) t[dones] = i;
            dones++;
         end
         if (dones > 0 && (bus.Data_out_Sum !== total[W-1:0] ||
                           bus.Data_out_Carry !== total[W])) unstable++;
      end
      bus.Start = 1'b0;
      check("held start done count", 64'(dones), 64'(3));
      check("held start first latency", 64'(t[0]), 64'(W));
      check("held start period 1", 64'(t[1] - t[0]), 64'(W + 2));
      check("held start period 2", 64'(t[2] - t[1]), 64'(W + 2));
      check("held start stable outputs", 64'(unstable), 64'(0));
      @(negedge clk);
      check("held start idle after release", 64'(bus.Busy), 64'(0));
      last_sum   = total[W-1:0];
      last_carry = total[W];

      // Randomized operands against the arithmetic reference.
      for (int i = 0; i < 20; i++) begin
         run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder that sequences WIDTH-bit operands LSB-first through a single 1-bit full-adder cell.
- Stores the ripple carry in a flip-flop between cycles and collects sum bits in a shift register.
- Sits directly upstream of the full-adder cell: it generates the cell's A/B/C inputs every cycle and consumes its Sum/Carry outputs.
- Start/Done handshake toward the requesting logic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Data_in_A  input  WIDTH  operand A; sampled only on an accepted Start.
- Data_in_B  input  WIDTH  operand B; sampled only on an accepted Start.
- Data_in_Cin  input  1  initial carry-in; sampled only on an accepted Start.
- Start  input  1  request; accepted only in IDLE.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; result valid.
- Data_out_Sum  output  WIDTH  registered sum; held until the next Done.
- Data_out_Carry  output  1  registered final carry-out; held until the next Done.

Behaviour:
- Reset (rst=1 at any clock edge, including mid-operation):
  - state=IDLE.
  - Busy=0, Done=0, Data_out_Sum=0, Data_out_Carry=0.
  - Shift registers, carry flip-flop and bit counter cleared.
  - An in-flight operation is discarded; no Done is produced.
- States:
  - IDLE: Start=1 at edge k latches A->shA, B->shB, Cin->cy, cnt<=0, sumsh<=0; next state RUN.
  - RUN: each edge:
    - Cell inputs are shA[0], shB[0], cy.
    - cy <= cell carry.
    - sumsh <= {cell sum, sumsh[WIDTH-1:1]}.
    - shA and shB shift right by one.
    - cnt++.
    - When cnt==WIDTH-1 at the edge: next state DONE; Data_out_Sum <= final sumsh value; Data_out_Carry <= cell carry.
  - DONE: Done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: Start accepted at edge k; RUN covers edges k+1..k+WIDTH; Done is high in the cycle between edges k+WIDTH and k+WIDTH+1. Throughput is one add per WIDTH+2 cycles.
- Start while Busy=1 (RUN or DONE) is ignored; it is not queued. Operand inputs may change freely after acceptance.
- Start held high continuously: re-accepted in the first IDLE cycle after DONE.
- Data_out_Sum/Data_out_Carry change only at the DONE transition and are stable at all other times, including during the next RUN.
- Carry chain arithmetic: {Carry,Sum} = A + B + Cin, modulo 2^(WIDTH+1).
- Done and Busy are driven from state; no combinational path from Start.

Optional Feature:
- Macro: SERIAL_ADD_OVERFLOW_EN.
- With the macro defined:
  - Extra output Data_out_Overflow (1 bit), the two's-complement signed overflow, equal to (carry into MSB) XOR (carry out of MSB).
  - Captured on the MSB RUN cycle; updated and held with Data_out_Sum.
  - Reset value 0.
- Without the macro: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - localparam/function for counter width = $clog2(WIDTH).
  - Default WIDTH constant.
- One sub-module instance: the existing 1-bit full_adder cell (Data_in_A, Data_in_B, Data_in_C, Data_out_Sum, Data_out_Carry), instantiated once. The block does not duplicate adder logic.

Test Plan:
- WIDTH=8, A=0x5A, B=0x33, Cin=0, Start at edge k -> Busy=1 from k; Done pulses exactly in cycle k+8..k+9; Sum=0x8D, Carry=0.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1, Overflow=0 (if _EN); then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Carry=1.
- A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Carry=0, Overflow=1 (if _EN); A=0x80, B=0x80 -> Sum=0x00, Carry=1, Overflow=1.
- Start=1 with new operands at edge k+3 of a run -> ignored; result matches original operands; only one Done.
- rst=1 at edge k+4 mid-run -> all outputs 0, IDLE next cycle, no Done; fresh Start afterwards produces the correct result.
- Start held high for 30 cycles with fixed operands -> Done every 10 cycles; outputs constant between pulses.
